// File: rtl/gpr_regfile.sv
// General-purpose register file: x0 hardwired to zero, one synchronous write port, two combinational read ports.
// Optional write-to-read forwarding is enabled by defining GPR_REGFILE_BYPASS_EN.
module gpr_regfile #(
    parameter int              XLEN      = 64,
    parameter int              NR_REG    = 32,
    parameter int              REG_SEL   = 5,
    parameter logic [XLEN-1:0] RESET_VAL = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wen,
    input  logic [REG_SEL-1:0] waddr,
    input  logic [XLEN-1:0]    wdata,
    input  logic [REG_SEL-1:0] raddr1,
    output logic [XLEN-1:0]    rdata1,
    input  logic [REG_SEL-1:0] raddr2,
    output logic [XLEN-1:0]    rdata2,
    output logic [NR_REG-1:0]  wsel
);

    logic [NR_REG-1:0] dec_keys_hit;
    logic [NR_REG-1:0] dec_onehot;
    logic [XLEN-1:0]   store [1:NR_REG-1];
    logic [XLEN-1:0]   view  [NR_REG];

    // Key/value lookup: key k (k>=1) selects value 1<<k; key 0 and any unmatched key fall to the all-zero default.
    always_comb begin
        dec_keys_hit = '0;
        dec_onehot   = '0;
        for (int k = 1; k < NR_REG; k++) begin
            if (waddr == REG_SEL'(k)) begin
                dec_keys_hit[k] = 1'b1;
            end
        end
        for (int k = 1; k < NR_REG; k++) begin
            if (dec_keys_hit[k]) begin
                dec_onehot = dec_onehot | (NR_REG'(1) << k);
            end
        end
    end

    assign wsel = wen ? dec_onehot : '0;

    for (genvar i = 1; i < NR_REG; i++) begin : g_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                store[i] <= RESET_VAL;
            end else if (wsel[i]) begin
                store[i] <= wdata;
            end
        end
    end

    // x0 has no storage; it is stitched in as a constant so the read mux can index uniformly.
    always_comb begin
        view[0] = '0;
        for (int i = 1; i < NR_REG; i++) begin
            view[i] = store[i];
        end
    end

`ifdef GPR_REGFILE_BYPASS_EN
    logic fwd1;
    logic fwd2;

    assign fwd1   = wen && (waddr != '0) && (raddr1 == waddr);
    assign fwd2   = wen && (waddr != '0) && (raddr2 == waddr);
    assign rdata1 = fwd1 ? wdata : view[raddr1];
    assign rdata2 = fwd2 ? wdata : view[raddr2];
`else
    assign rdata1 = view[raddr1];
    assign rdata2 = view[raddr2];
`endif

endmodule

// File: tb/tb_gpr_regfile.sv
// Directed bench for gpr_regfile: a reference model plus an expectation queue drained at each check point.
// Honors GPR_REGFILE_BYPASS_EN the same way the design does when computing expected reads.
module tb_gpr_regfile;

    localparam int XLEN    = 64;
    localparam int NR_REG  = 32;
    localparam int REG_SEL = 5;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               wen = 1'b0;
    logic [REG_SEL-1:0] waddr = '0;
    logic [XLEN-1:0]    wdata = '0;
    logic [REG_SEL-1:0] raddr1 = '0;
    logic [XLEN-1:0]    rdata1;
    logic [REG_SEL-1:0] raddr2 = '0;
    logic [XLEN-1:0]    rdata2;
    logic [NR_REG-1:0]  wsel;

    typedef struct {
        int          kind;
        logic [63:0] exp;
        string       tag;
    } exp_t;

    exp_t        scoreboard[$];
    logic [63:0] model [NR_REG];
    int          checks = 0;
    int          errors = 0;

    gpr_regfile #(
        .XLEN     (XLEN),
        .NR_REG   (NR_REG),
        .REG_SEL  (REG_SEL),
        .RESET_VAL('0)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .wen   (wen),
        .waddr (waddr),
        .wdata (wdata),
        .raddr1(raddr1),
        .rdata1(rdata1),
        .raddr2(raddr2),
        .rdata2(rdata2),
        .wsel  (wsel)
    );

    always #5 clk = ~clk;

    // Reference register state, updated from what the bench itself drives.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NR_REG; i++) model[i] <= '0;
        end else if (wen && waddr != '0) begin
            model[waddr] <= wdata;
        end
    end

    function automatic logic [63:0] exp_read(input logic [REG_SEL-1:0] a);
`ifdef GPR_REGFILE_BYPASS_EN
        if (wen && waddr != '0 && a == waddr) return wdata;
`endif
        if (a == '0) return '0;
        return model[a];
    endfunction

    function automatic logic [63:0] exp_wsel();
        logic [63:0] v;
        v = '0;
        if (wen && waddr != '0) v[waddr] = 1'b1;
        return v;
    endfunction

    task automatic applyStimulus(input logic w, input logic [REG_SEL-1:0] wa, input logic [XLEN-1:0] wd,
                                 input logic [REG_SEL-1:0] r1, input logic [REG_SEL-1:0] r2);
        @(negedge clk);
        wen    = w;
        waddr  = wa;
        wdata  = wd;
        raddr1 = r1;
        raddr2 = r2;
        #1;
    endtask

    task automatic pushExpect(input int kind, input logic [63:0] exp, input string tag);
        exp_t e;
        e.kind = kind;
        e.exp  = exp;
        e.tag  = tag;
        scoreboard.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [63:0] obs;
        while (scoreboard.size() > 0) begin
            e = scoreboard.pop_front();
            case (e.kind)
                0:       obs = rdata1;
                1:       obs = rdata2;
                default: obs = {32'b0, wsel};
            endcase
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("[TB] FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NR_REG; i++) model[i] = '0;

        // Initial reset, then seed register 10 so the mid-cycle reset has something to clear.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        applyStimulus(1'b1, 5'd10, 64'h0000_0000_0000_0ABC, 5'd10, 5'd0);
        applyStimulus(1'b0, 5'd0, 64'h0, 5'd10, 5'd0);
        pushExpect(0, 64'h0000_0000_0000_0ABC, "seed_r10");
        pushExpect(0, exp_read(5'd10), "seed_r10_model");
        pushExpect(1, 64'h0, "seed_x0");
        checkOutput();

        // Reset pulse inside the low phase, with no clock edge.
        applyStimulus(1'b1, 5'd9, 64'h1234, 5'd10, 5'd0);
        rst = 1'b1;
        #1;
        pushExpect(0, 64'h0, "rst_async_r10");
        pushExpect(2, 64'h0000_0000_0000_0200, "rst_wsel_ungated");
        checkOutput();
        for (int a = 0; a < NR_REG; a++) begin
            raddr1 = REG_SEL'(a);
            raddr2 = REG_SEL'(NR_REG - 1 - a);
            #0.1;
            pushExpect(0, 64'h0, $sformatf("rst_rd1_a%0d", a));
            pushExpect(1, 64'h0, $sformatf("rst_rd2_a%0d", NR_REG - 1 - a));
            checkOutput();
        end
        wen = 1'b0;
        #0.5;
        rst = 1'b0;

        // Write then read, neighbours untouched.
        applyStimulus(1'b1, 5'd5, 64'hDEAD_BEEF_0123_4567, 5'd0, 5'd0);
        applyStimulus(1'b0, 5'd0, 64'h0, 5'd5, 5'd4);
        pushExpect(0, 64'hDEAD_BEEF_0123_4567, "wr_r5");
        pushExpect(1, 64'h0, "wr_r4_unchanged");
        checkOutput();
        applyStimulus(1'b0, 5'd0, 64'h0, 5'd6, 5'd5);
        pushExpect(0, 64'h0, "wr_r6_unchanged");
        pushExpect(1, exp_read(5'd5), "wr_r5_port2");
        checkOutput();

        // x0 protection.
        applyStimulus(1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd0);
        pushExpect(2, 64'h0, "x0_wsel_zero");
        pushExpect(0, 64'h0, "x0_read_pre");
        checkOutput();
        applyStimulus(1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
        pushExpect(0, 64'h0, "x0_read_post");
        pushExpect(2, 64'h0, "x0_wsel_idle");
        checkOutput();

        // Decode sweep; each step also commits a write that the model tracks.
        for (int a = 1; a < NR_REG; a++) begin
            applyStimulus(1'b1, REG_SEL'(a), 64'(a) * 64'h0101_0101_0000_0011, REG_SEL'(a), REG_SEL'(a - 1));
            pushExpect(2, 64'h1 << a, $sformatf("dec_wsel_a%0d", a));
            pushExpect(2, exp_wsel(), $sformatf("dec_wsel_model_a%0d", a));
            pushExpect(1, exp_read(REG_SEL'(a - 1)), $sformatf("dec_prev_a%0d", a - 1));
            checkOutput();
        end
        applyStimulus(1'b0, 5'd17, 64'h0, 5'd31, 5'd17);
        pushExpect(2, 64'h0, "dec_wen0");
        pushExpect(0, 64'd31 * 64'h0101_0101_0000_0011, "dec_r31");
        pushExpect(1, 64'd17 * 64'h0101_0101_0000_0011, "dec_r17");
        checkOutput();

        // Same-cycle read and write of register 7.
        applyStimulus(1'b1, 5'd7, 64'h11, 5'd0, 5'd0);
        applyStimulus(1'b1, 5'd7, 64'h22, 5'd7, 5'd7);
`ifdef GPR_REGFILE_BYPASS_EN
        pushExpect(1, 64'h22, "rw_same_cycle");
`else
        pushExpect(1, 64'h11, "rw_same_cycle");
`endif
        pushExpect(0, exp_read(5'd7), "rw_same_cycle_model");
        checkOutput();
        applyStimulus(1'b0, 5'd0, 64'h0, 5'd0, 5'd7);
        pushExpect(1, 64'h22, "rw_after_edge");
        checkOutput();

        // Reset held across a write edge wins.
        applyStimulus(1'b1, 5'd3, 64'h99, 5'd3, 5'd7);
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        applyStimulus(1'b0, 5'd0, 64'h0, 5'd3, 5'd7);
        pushExpect(0, 64'h0, "rst_vs_write_r3");
        pushExpect(1, 64'h0, "rst_vs_write_r7");
        checkOutput();

        // First write after reset release lands on the next edge.
        applyStimulus(1'b1, 5'd3, 64'h99, 5'd3, 5'd3);
        applyStimulus(1'b0, 5'd0, 64'h0, 5'd3, 5'd0);
        pushExpect(0, 64'h99, "post_rst_write");
        checkOutput();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
